// File: rtl/lsu_wb_fifo_pkg.sv
// Shared LSU/CDB result types: the broadcast record carried from the LSU to CDB arbitration.
package lsu_wb_fifo_pkg;

   localparam int ROB_ID_W = 5;
   localparam int XLEN     = 32;

   typedef struct packed {
      logic [ROB_ID_W-1:0] rob_id;
      logic [XLEN-1:0]     value;
      logic                exception;
      logic                is_store;
   } cdb_info_t;

endpackage

// File: rtl/lsu_wb_fifo.sv
// In-order LSU result buffer ahead of the CDB arbiter; push-to-valid 1 cycle (0 with LSU_WB_FIFO_BYPASS_EN), refuses input only when full.
// lsu_ready_o depends on registered occupancy only, so cdb_ready_i never reaches the LSU combinationally.
module lsu_wb_fifo
   import lsu_wb_fifo_pkg::*;
#(
   parameter int  DEPTH   = 4,
   localparam int PTR_LEN = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             lsu_valid_i,
   output logic             lsu_ready_o,
   input  cdb_info_t        lsu_result_i,
   output logic             cdb_valid_o,
   input  logic             cdb_ready_i,
   output cdb_info_t        cdb_result_o,
   output logic [PTR_LEN:0] count_o
);

   localparam logic [PTR_LEN:0]   FULL_CNT = (PTR_LEN+1)'(DEPTH);
   localparam logic [PTR_LEN:0]   CNT_ONE  = (PTR_LEN+1)'(1);
   localparam logic [PTR_LEN-1:0] PTR_ONE  = PTR_LEN'(1);

   cdb_info_t          mem [DEPTH];
   logic [PTR_LEN-1:0] head;
   logic [PTR_LEN-1:0] tail;
   logic [PTR_LEN:0]   count;

   logic empty;
   logic push;
   logic pop;
   logic wr_en;
   logic rd_en;
   logic clr;

   assign clr         = rst | flush;
   assign empty       = (count == '0);
   assign lsu_ready_o = (count != FULL_CNT);
   assign push        = lsu_valid_i & lsu_ready_o;
   assign count_o     = count;

`ifdef LSU_WB_FIFO_BYPASS_EN
   logic bypass;

   // An empty buffer forwards the incoming result straight to the arbiter.
   assign bypass      = empty & lsu_valid_i;
   assign cdb_valid_o = ~empty | bypass;
   assign pop         = cdb_valid_o & cdb_ready_i;
   assign wr_en       = push & ~(bypass & cdb_ready_i);
   assign rd_en       = pop & ~empty;

   always_comb begin
      cdb_result_o = '0;
      if (!empty) begin
         cdb_result_o = mem[head];
      end else if (bypass) begin
         cdb_result_o = lsu_result_i;
      end
   end
`else
   assign cdb_valid_o = ~empty;
   assign pop         = cdb_valid_o & cdb_ready_i;
   assign wr_en       = push;
   assign rd_en       = pop;

   always_comb begin
      cdb_result_o = '0;
      if (!empty) begin
         cdb_result_o = mem[head];
      end
   end
`endif

   // Storage is left uncleared; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (wr_en && !clr) begin
         mem[tail] <= lsu_result_i;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (wr_en) begin
            tail <= tail + PTR_ONE;
         end
         if (rd_en) begin
            head <= head + PTR_ONE;
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         assert (!(rd_en && empty));
         assert (!(wr_en && (count == FULL_CNT)));
      end
   end

endmodule

// File: tb/tb_lsu_wb_fifo.sv
// Directed bench for lsu_wb_fifo: queue reference model checked every cycle plus literal checkpoints.
module tb_lsu_wb_fifo;
   import lsu_wb_fifo_pkg::*;

   localparam int DEPTH = 4;

   logic      clk = 1'b0;
   logic      rst;
   logic      flush;
   logic      lsu_valid_i;
   logic      lsu_ready_o;
   cdb_info_t lsu_result_i;
   logic      cdb_valid_o;
   logic      cdb_ready_i;
   cdb_info_t cdb_result_o;
   logic [2:0] count_o;

   int checks   = 0;
   int failures = 0;
   bit started  = 1'b0;
   cdb_info_t q[$];

   always #5 clk = ~clk;

   lsu_wb_fifo #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .lsu_valid_i  (lsu_valid_i),
      .lsu_ready_o  (lsu_ready_o),
      .lsu_result_i (lsu_result_i),
      .cdb_valid_o  (cdb_valid_o),
      .cdb_ready_i  (cdb_ready_i),
      .cdb_result_o (cdb_result_o),
      .count_o      (count_o)
   );

   function automatic cdb_info_t mk(input int rob);
      cdb_info_t r;
      r.rob_id    = rob[4:0];
      r.value     = 32'hA500_0000 + rob;
      r.exception = rob[0];
      r.is_store  = rob[1];
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: a bounded queue; full refuses, empty cannot pop.
   always @(posedge clk) begin
      if (rst || flush) begin
         q.delete();
      end else begin : model
         int n;
         bit do_push;
         n = q.size();
         do_push = lsu_valid_i && (n < DEPTH);
`ifdef LSU_WB_FIFO_BYPASS_EN
         if (n == 0 && lsu_valid_i && cdb_ready_i) do_push = 1'b0;
`endif
         if (cdb_ready_i && n > 0) void'(q.pop_front());
         if (do_push) q.push_back(lsu_result_i);
      end
   end

   always @(negedge clk) begin
      if (started) begin : cmp
         cdb_info_t e;
         bit ev;
         ev = (q.size() != 0);
         e  = ev ? q[0] : '0;
`ifdef LSU_WB_FIFO_BYPASS_EN
         if (!ev && lsu_valid_i) begin
            ev = 1'b1;
            e  = lsu_result_i;
         end
`endif
         chk("model_ready",  lsu_ready_o,  (q.size() != DEPTH));
         chk("model_valid",  cdb_valid_o,  ev);
         chk("model_result", cdb_result_o, e);
         chk("model_count",  count_o,      q.size());
      end
   end

   initial begin
      rst = 1'b1; flush = 1'b0; lsu_valid_i = 1'b0; cdb_ready_i = 1'b0; lsu_result_i = '0;
      tick();
      rst = 1'b0;
      started = 1'b1;

      // 1. reset state
      chk("rst_ready",  lsu_ready_o,  1);
      chk("rst_valid",  cdb_valid_o,  0);
      chk("rst_count",  count_o,      0);
      chk("rst_result", cdb_result_o, 0);

      // 2. fill with 1..4, arbiter stalled
      for (int i = 1; i <= 4; i++) begin
         lsu_valid_i = 1'b1; lsu_result_i = mk(i);
         tick();
         if (i == 1) begin
            chk("first_valid", cdb_valid_o, 1);
            chk("first_rob",   cdb_result_o.rob_id, 1);
         end
      end
      lsu_result_i = mk(5);
      chk("full_ready", lsu_ready_o, 0);
      chk("full_count", count_o, 4);
      tick();
      chk("fifth_refused_count", count_o, 4);
      chk("stall_hold_rob", cdb_result_o.rob_id, 1);
      lsu_valid_i = 1'b0;

      // 3. drain in order
      cdb_ready_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk("drain_rob", cdb_result_o.rob_id, i);
         chk("drain_value", cdb_result_o.value, 32'hA500_0000 + i);
         tick();
      end
      cdb_ready_i = 1'b0;
      chk("drain_count", count_o, 0);
      chk("drain_valid", cdb_valid_o, 0);

      // 4. move head to 3, hold count 2 through six push+pop cycles
      for (int i = 10; i <= 12; i++) begin
         lsu_valid_i = 1'b1; lsu_result_i = mk(i);
         tick();
      end
      lsu_valid_i = 1'b0; cdb_ready_i = 1'b1;
      repeat (3) tick();
      cdb_ready_i = 1'b0;
      for (int i = 14; i <= 15; i++) begin
         lsu_valid_i = 1'b1; lsu_result_i = mk(i);
         tick();
      end
      for (int k = 0; k < 6; k++) begin
         lsu_valid_i = 1'b1; lsu_result_i = mk(16 + k); cdb_ready_i = 1'b1;
         chk("wrap_rob", cdb_result_o.rob_id, 14 + k);
         chk("wrap_count", count_o, 2);
         tick();
      end
      lsu_valid_i = 1'b0;
      chk("wrap_tail_rob", cdb_result_o.rob_id, 20);
      chk("wrap_tail_count", count_o, 2);
      repeat (2) tick();
      cdb_ready_i = 1'b0;
      chk("wrap_drained", count_o, 0);

      // 5. full with simultaneous offer and grant: pop only
      for (int i = 22; i <= 25; i++) begin
         lsu_valid_i = 1'b1; lsu_result_i = mk(i);
         tick();
      end
      lsu_result_i = mk(26); cdb_ready_i = 1'b1;
      chk("fullpop_ready_before", lsu_ready_o, 0);
      tick();
      lsu_valid_i = 1'b0; cdb_ready_i = 1'b0;
      chk("fullpop_count", count_o, 3);
      chk("fullpop_ready", lsu_ready_o, 1);
      chk("fullpop_head", cdb_result_o.rob_id, 23);

      // 6. flush with a concurrent push discards everything
      flush = 1'b1; lsu_valid_i = 1'b1; lsu_result_i = mk(27);
      tick();
      flush = 1'b0; lsu_valid_i = 1'b0;
      chk("flush_count", count_o, 0);
      chk("flush_valid", cdb_valid_o, 0);
      chk("flush_result", cdb_result_o, 0);
      lsu_valid_i = 1'b1; lsu_result_i = mk(28);
      tick();
      lsu_valid_i = 1'b0;
      chk("post_flush_count", count_o, 1);
      chk("post_flush_rob", cdb_result_o.rob_id, 28);

      // reset while pushing also wins
      rst = 1'b1; lsu_valid_i = 1'b1; lsu_result_i = mk(29);
      tick();
      rst = 1'b0; lsu_valid_i = 1'b0;
      chk("rst_push_count", count_o, 0);

`ifdef LSU_WB_FIFO_BYPASS_EN
      // 7. bypass: empty, offer and grant together
      lsu_valid_i = 1'b1; lsu_result_i = mk(7); cdb_ready_i = 1'b1;
      #1;
      chk("bypass_valid", cdb_valid_o, 1);
      chk("bypass_rob", cdb_result_o.rob_id, 7);
      tick();
      lsu_valid_i = 1'b0; cdb_ready_i = 1'b0;
      chk("bypass_count", count_o, 0);
`endif

      tick();
      started = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
